// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
//   - Default sizing constants for channel count, duty/counter width and period.
//   - pwm_duty_t: duty value type at the default counter width.
//   - duty_unpack(): extracts one channel's duty field from a packed duty bus.
package pwm_pkg;

   localparam int unsigned N_CH_DEF   = 3;
   localparam int unsigned CNT_W_DEF  = 8;
   localparam int unsigned PERIOD_DEF = 100;

   // Upper bounds that let duty_unpack() serve any legal instance size.
   localparam int unsigned MAX_CNT_W = 32;
   localparam int unsigned MAX_BUS_W = 1024;

   typedef logic [CNT_W_DEF-1:0] pwm_duty_t;

   // Channel idx occupies bits [idx*w +: w] of the bus; the result is zero-extended.
   function automatic logic [MAX_CNT_W-1:0] duty_unpack(input logic [MAX_BUS_W-1:0] bus,
                                                        input int unsigned idx,
                                                        input int unsigned w);
      logic [MAX_CNT_W-1:0] mask;
      mask = MAX_CNT_W'((64'd1 << w) - 64'd1);
      return MAX_CNT_W'(bus >> (idx * w)) & mask;
   endfunction

endpackage

// File: rtl/pwm_multi_channel_if.sv
// Duty load port of the multi-channel PWM generator (valid/ready).
//   duty_in     packed duty values, channel i at [i*CNT_W +: CNT_W]
//   duty_valid  duty_in is valid; source holds both until duty_ready
//   duty_ready  shadow register is free; a transfer happens on valid & ready
// master: the colour/brightness source. slave: the PWM block.
interface pwm_multi_channel_if
   import pwm_pkg::*;
#(
   parameter int unsigned N_CH  = N_CH_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
);

   logic [N_CH*CNT_W-1:0] duty_in;
   logic                  duty_valid;
   logic                  duty_ready;

   modport master (
      output duty_in,
      output duty_valid,
      input  duty_ready
   );

   modport slave (
      input  duty_in,
      input  duty_valid,
      output duty_ready
   );

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: active duty register, comparator and registered output.
// Optional fade stepper compiled in with PWM_FADE_EN.
//   clk, sys_rst_n  clock, asynchronous active-low reset
//   en              count enable; low holds the output
//   apply           wrap with an update pending: move active toward shadow
//   shadow          target duty for this channel
//   cnt_next        value the shared counter takes at this edge
//   pwm_out         registered PWM output
//   at_target       active (after this edge) equals shadow
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned FADE_STEP = 1
) (
   input  logic             clk,
   input  logic             sys_rst_n,
   input  logic             en,
   input  logic             apply,
   input  logic [CNT_W-1:0] shadow,
   input  logic [CNT_W-1:0] cnt_next,
   output logic             pwm_out,
   output logic             at_target
);

   logic [CNT_W-1:0] active_q, active_d;
   logic             pwm_q, pwm_d;

`ifdef PWM_FADE_EN
   localparam logic [CNT_W-1:0] STEP = CNT_W'(FADE_STEP);

   // Step toward the target, saturating on it.
   always_comb begin
      active_d = active_q;
      if (apply) begin
         if (active_q < shadow) begin
            active_d = ((shadow - active_q) > STEP) ? active_q + STEP : shadow;
         end else if (active_q > shadow) begin
            active_d = ((active_q - shadow) > STEP) ? active_q - STEP : shadow;
         end
      end
   end
`else
   logic unused_fade_step;
   assign unused_fade_step = ^CNT_W'(FADE_STEP);

   always_comb begin
      active_d = active_q;
      if (apply) begin
         active_d = shadow;
      end
   end
`endif

   // Compare against the next count and next duty so the output is aligned with the counter:
   // the first cycle of a period already shows the newly applied duty.
   always_comb begin
      pwm_d = pwm_q;
      if (en) begin
         pwm_d = (cnt_next < active_d);
      end
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         active_q <= '0;
         pwm_q    <= 1'b0;
      end else begin
         active_q <= active_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_out   = pwm_q;
   assign at_target = (active_d == shadow);

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator with a shared period counter and double-buffered duty values.
// New duties are accepted into a shadow register and applied only at period wraps, so outputs
// never glitch mid-period. Define PWM_FADE_EN to step duties toward their targets by FADE_STEP
// per period instead of jumping.
//   clk, sys_rst_n  clock, asynchronous active-low reset
//   en              count enable; low freezes counter, pwm_out, period_start
//   load            duty load port (slave): duty_in, duty_valid, duty_ready
//   pwm_out         registered PWM outputs, one per channel
//   period_start    one-cycle pulse in the first cycle of each period (cnt=0)
//   busy            an update is pending in the shadow register
module pwm_multi_channel
   import pwm_pkg::*;
#(
   parameter int unsigned N_CH      = N_CH_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned PERIOD    = PERIOD_DEF,
   parameter int unsigned FADE_STEP = 1
) (
   input  logic                   clk,
   input  logic                   sys_rst_n,
   input  logic                   en,
   pwm_multi_channel_if.slave     load,
   output logic [N_CH-1:0]        pwm_out,
   output logic                   period_start,
   output logic                   busy
);

   // PERIOD is legal in 2..2^CNT_W, so PERIOD-1 always fits the counter.
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [N_CH*CNT_W-1:0] shadow_q, shadow_d;
   logic                  pending_q, pending_d;
   logic                  period_start_q;
   logic                  wrap, xfer, apply;
   logic [N_CH-1:0]       at_target;

   assign wrap  = en && (cnt_q == CNT_MAX);
   assign xfer  = load.duty_valid && !pending_q;
   assign apply = wrap && pending_q;

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // xfer only happens with pending clear and apply only with pending set, so a load landing
   // on a wrap always waits for the following wrap.
   always_comb begin
      shadow_d  = shadow_q;
      pending_d = pending_q;
      if (xfer) begin
         shadow_d  = load.duty_in;
         pending_d = 1'b1;
      end else if (apply && (&at_target)) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_q          <= '0;
         shadow_q       <= '0;
         pending_q      <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         shadow_q       <= shadow_d;
         pending_q      <= pending_d;
         period_start_q <= wrap;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [CNT_W-1:0] shadow_ch;

      assign shadow_ch = CNT_W'(duty_unpack(MAX_BUS_W'(shadow_q), i, CNT_W));

      pwm_channel #(
         .CNT_W     (CNT_W),
         .FADE_STEP (FADE_STEP)
      ) u_ch (
         .clk       (clk),
         .sys_rst_n (sys_rst_n),
         .en        (en),
         .apply     (apply),
         .shadow    (shadow_ch),
         .cnt_next  (cnt_d),
         .pwm_out   (pwm_out[i]),
         .at_target (at_target[i])
      );
   end

   assign load.duty_ready = !pending_q;
   assign period_start    = period_start_q;
   assign busy            = pending_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel (N_CH=3, CNT_W=8, PERIOD=100, FADE_STEP=10).
// Default build checks direct duty application; with PWM_FADE_EN it checks the fade sequence.
module tb_pwm_multi_channel;
   import pwm_pkg::*;

   localparam int unsigned N_CH      = 3;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned PERIOD    = 100;
   localparam int unsigned FADE_STEP = 10;

   logic            clk = 1'b0;
   logic            sys_rst_n = 1'b0;
   logic            en = 1'b0;
   logic [N_CH-1:0] pwm_out;
   logic            period_start;
   logic            busy;

   pwm_multi_channel_if #(.N_CH(N_CH), .CNT_W(CNT_W)) load_if ();

   pwm_multi_channel #(
      .N_CH      (N_CH),
      .CNT_W     (CNT_W),
      .PERIOD    (PERIOD),
      .FADE_STEP (FADE_STEP)
   ) dut (
      .clk          (clk),
      .sys_rst_n    (sys_rst_n),
      .en           (en),
      .load         (load_if),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      pwm_duty_t r, g, b;
      int        hr, hg, hb;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_duty(input pwm_duty_t r, input pwm_duty_t g, input pwm_duty_t b);
      load_if.duty_in    = {b, g, r};
      load_if.duty_valid = 1'b1;
      tick();
      load_if.duty_valid = 1'b0;
   endtask

   // Advance until period_start is seen; n = edges taken.
   task automatic wait_ps(output int n);
      int k;
      k = 0;
      do begin
         tick();
         k++;
      end while (!period_start && k < 400);
      check("period_start_seen", int'(period_start), 1);
      n = k;
   endtask

   // From a period_start sample, count high cycles per channel up to the next period_start.
   task automatic measure(output int h0, output int h1, output int h2, output int len);
      int a0, a1, a2, k;
      a0 = 0; a1 = 0; a2 = 0; k = 0;
      do begin
         a0 += int'(pwm_out[0]);
         a1 += int'(pwm_out[1]);
         a2 += int'(pwm_out[2]);
         tick();
         k++;
      end while (!period_start && k < 400);
      h0 = a0; h1 = a1; h2 = a2; len = k;
   endtask

   task automatic check_period(input string name, input int e0, input int e1, input int e2);
      int h0, h1, h2, len;
      measure(h0, h1, h2, len);
      check({name, "_len"}, len, int'(PERIOD));
      check({name, "_hi_r"}, h0, e0);
      check({name, "_hi_g"}, h1, e1);
      check({name, "_hi_b"}, h2, e2);
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_pwm_out"}, int'(pwm_out), 0);
      check({name, "_period_start"}, int'(period_start), 0);
      check({name, "_duty_ready"}, int'(load_if.duty_ready), 1);
      check({name, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      int n;
      int frozen_bad;

      vecs[0] = '{8'd25,  8'd50,  8'd100, 25,  50,  100};
      vecs[1] = '{8'd0,   8'd1,   8'd99,  0,   1,   99};
      vecs[2] = '{8'd200, 8'd255, 8'd0,   100, 100, 0};
      vecs[3] = '{8'd0,   8'd0,   8'd0,   0,   0,   0};
      vecs[4] = '{8'd100, 8'd99,  8'd2,   100, 99,  2};

      load_if.duty_in    = '0;
      load_if.duty_valid = 1'b0;

      #12;
      check_reset_state("reset");
      @(posedge clk);
      #1;
      sys_rst_n = 1'b1;
      en        = 1'b1;

      // No load: outputs low, period_start every PERIOD cycles.
      check_period("idle0", 0, 0, 0);
      check_period("idle1", 0, 0, 0);

`ifndef PWM_FADE_EN
      // Load at cycle 10 of a period.
      repeat (10) tick();
      load_duty(8'd25, 8'd50, 8'd100);
      check("load10_ready_low", int'(load_if.duty_ready), 0);
      check("load10_busy", int'(busy), 1);
      wait_ps(n);
      check("load10_wrap_dist", n, 89);
      check("load10_ready_back", int'(load_if.duty_ready), 1);
      check("load10_busy_clear", int'(busy), 0);
      check_period("load10", 25, 50, 100);

      // Load on the exact wrap edge: not applied until one period later.
      repeat (99) tick();
      load_duty(8'd5, 8'd60, 8'd0);
      check("wrapload_ps", int'(period_start), 1);
      check("wrapload_busy", int'(busy), 1);
      check_period("wrapload_old", 25, 50, 100);
      check("wrapload_busy_clear", int'(busy), 0);
      check("wrapload_first_pwm", int'(pwm_out), 3'b011);
      check_period("wrapload_new", 5, 60, 0);

      // duty_valid held while busy: only the first value goes in; the held one on ready's rise.
      load_if.duty_in    = {8'd7, 8'd0, 8'd40};
      load_if.duty_valid = 1'b1;
      tick();
      load_if.duty_in = {8'd255, 8'd90, 8'd12};
      check("hold_ready_low", int'(load_if.duty_ready), 0);
      wait_ps(n);
      check("hold_wrap_dist", n, 99);
      check("hold_ready_rise", int'(load_if.duty_ready), 1);
      check("hold_first_pwm", int'(pwm_out), 3'b101);
      tick();
      load_if.duty_valid = 1'b0;
      check("hold_second_xfer", int'(busy), 1);
      wait_ps(n);
      check("hold_second_pwm", int'(pwm_out), 3'b111);
      check_period("hold_second", 12, 90, 100);

      // en low for 37 cycles mid-period.
      repeat (20) tick();
      check("freeze_pwm_before", int'(pwm_out), 3'b110);
      en         = 1'b0;
      frozen_bad = 0;
      repeat (37) begin
         tick();
         if (pwm_out != 3'b110 || period_start) frozen_bad++;
      end
      check("freeze_held_cycles_bad", frozen_bad, 0);
      en = 1'b1;
      wait_ps(n);
      check("freeze_resume_dist", n, 80);
      check_period("freeze_after", 12, 90, 100);

      // Table of duty loads; each applied at the following wrap.
      for (int i = 0; i < 5; i++) begin
         load_duty(vecs[i].r, vecs[i].g, vecs[i].b);
         wait_ps(n);
         check($sformatf("vec%0d_wrap_dist", i), n, 99);
         check_period($sformatf("vec%0d", i), vecs[i].hr, vecs[i].hg, vecs[i].hb);
      end

      // Reset mid-period with an update pending.
      repeat (30) tick();
      load_duty(8'd50, 8'd50, 8'd50);
      check("rst_pending_busy", int'(busy), 1);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check_reset_state("rst_mid");
`else
      begin
         int exp_r[4];
         int exp_g[4];
         int exp_busy[4];
         exp_r    = '{10, 20, 30, 35};
         exp_g    = '{10, 20, 20, 20};
         exp_busy = '{1, 1, 1, 0};

         load_duty(8'd35, 8'd20, 8'd0);
         check("fade_ready_low", int'(load_if.duty_ready), 0);
         wait_ps(n);
         check("fade_wrap_dist", n, 99);
         for (int k = 0; k < 4; k++) begin
            check($sformatf("fade%0d_busy", k), int'(busy), exp_busy[k]);
            check($sformatf("fade%0d_ready", k), int'(load_if.duty_ready), 1 - exp_busy[k]);
            check_period($sformatf("fade%0d", k), exp_r[k], exp_g[k], 0);
         end
      end

      // Reset mid-fade (fading back down toward zero).
      load_duty(8'd0, 8'd0, 8'd0);
      wait_ps(n);
      check("fadedown_busy", int'(busy), 1);
      repeat (40) tick();
      #2;
      sys_rst_n = 1'b0;
      #1;
      check_reset_state("rst_mid_fade");
`endif

      @(posedge clk);
      #1;
      sys_rst_n = 1'b1;
      check_period("post_rst0", 0, 0, 0);
      check("post_rst_busy", int'(busy), 0);
      check_period("post_rst1", 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
